// File: rtl/freq_gate_sequencer.sv
// Purpose: settle/gate sequencer for the frequency meter; counts sigIn rising edges over a fixed sysClk gate.
// Latency: resultValid rises the cycle after the last gate cycle; sigIn edges lag SYNC_STAGES+1 cycles.
// Backpressure: result, overflow and resultValid are held in DONE until resultReady; start is ignored meanwhile.
module freq_gate_sequencer #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sysClk,
    input  logic             sysRst,
    input  logic             start,
    input  logic             abort,
    output logic             relaxEnable,
    input  logic             relaxSignal,
    input  logic             sigIn,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             resultValid,
    input  logic             resultReady,
    output logic             overflow
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                   prevSample;
    logic                   sigEdge;
    logic [CNT_W-1:0]       edgeCnt;
    logic [GATE_W-1:0]      gateCnt;
    logic                   countInc;
    logic                   countSat;

    // Bring sigIn into the sysClk domain and keep one extra sample for edge detection.
    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            syncReg    <= '0;
            prevSample <= 1'b0;
        end else begin
            syncReg    <= {syncReg[SYNC_STAGES-2:0], sigIn};
            prevSample <= syncReg[SYNC_STAGES-1];
        end
    end

    assign sigEdge  = syncReg[SYNC_STAGES-1] & ~prevSample;
    // An edge either advances the count or, once the count is pinned at max, flags overflow.
    assign countInc = sigEdge && (edgeCnt != CNT_MAX);
    assign countSat = sigEdge && (edgeCnt == CNT_MAX);

    // Sequencer: IDLE -> SETTLE -> GATE -> DONE, abort back to IDLE from anywhere.
    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            state       <= IDLE;
            relaxEnable <= 1'b0;
            busy        <= 1'b0;
            result      <= '0;
            resultValid <= 1'b0;
            overflow    <= 1'b0;
            edgeCnt     <= '0;
            gateCnt     <= '0;
        end else if (abort) begin
            state       <= IDLE;
            relaxEnable <= 1'b0;
            busy        <= 1'b0;
            resultValid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SETTLE;
                        relaxEnable <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (relaxSignal) begin
                        state    <= GATE;
                        edgeCnt  <= '0;
                        gateCnt  <= '0;
                        overflow <= 1'b0;
                    end
                end
                GATE: begin
                    if (countInc) begin
                        edgeCnt <= edgeCnt + CNT_W'(1);
                    end
                    if (countSat) begin
                        overflow <= 1'b1;
                    end
                    if (gateCnt == GATE_LAST) begin
                        // Fold in this cycle's edge so the final gate cycle is counted.
                        result      <= edgeCnt + CNT_W'(countInc);
                        resultValid <= 1'b1;
                        relaxEnable <= 1'b0;
                        state       <= DONE;
                    end else begin
                        // Stops at GATE_LAST, so the counter never wraps.
                        gateCnt <= gateCnt + GATE_W'(1);
                    end
                end
                DONE: begin
                    if (resultValid && resultReady) begin
                        state       <= IDLE;
                        resultValid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Purpose: bench for freq_gate_sequencer; two instances (5-bit and 4-bit counts) share all inputs.
// Latency: expected counts come from recorded sigIn samples over the gate window, shifted by the synchronizer depth.
// Backpressure: resultReady is held low in DONE for directed and random stretches while start is pulsed.
module tb_freq_gate_sequencer;

    localparam int G  = 100;
    localparam int S  = 2;
    localparam int WA = 5;
    localparam int WB = 4;

    logic          sysClk = 1'b0;
    logic          sysRst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          relaxSignal = 1'b0;
    logic          sigIn = 1'b0;
    logic          resultReady = 1'b0;
    logic          relaxEnableA, busyA, resultValidA, overflowA;
    logic          relaxEnableB, busyB, resultValidB, overflowB;
    logic [WA-1:0] resultA;
    logic [WB-1:0] resultB;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;
    int phase = 0;
    int expResA = 0;
    int expResB = 0;
    bit sHist [65536];

    freq_gate_sequencer #(.GATE_CYCLES(G), .CNT_W(WA), .SYNC_STAGES(S)) dutA (
        .sysClk(sysClk), .sysRst(sysRst), .start(start), .abort(abort),
        .relaxEnable(relaxEnableA), .relaxSignal(relaxSignal), .sigIn(sigIn),
        .busy(busyA), .result(resultA), .resultValid(resultValidA),
        .resultReady(resultReady), .overflow(overflowA)
    );

    freq_gate_sequencer #(.GATE_CYCLES(G), .CNT_W(WB), .SYNC_STAGES(S)) dutB (
        .sysClk(sysClk), .sysRst(sysRst), .start(start), .abort(abort),
        .relaxEnable(relaxEnableB), .relaxSignal(relaxSignal), .sigIn(sigIn),
        .busy(busyB), .result(resultB), .resultValid(resultValidB),
        .resultReady(resultReady), .overflow(overflowB)
    );

    always #5 sysClk = ~sysClk;

    // Record the sigIn value seen at every rising edge; cyc is the index of the next edge.
    always @(posedge sysClk) begin
        if (cyc < 65536) sHist[cyc] = sigIn;
        cyc = cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then drive the next sigIn sample for the active waveform mode.
    task automatic tick();
        @(posedge sysClk);
        #1;
        phase++;
        case (mode)
            0:       sigIn = 1'($urandom % 2);
            1:       sigIn = ((phase % 10) < 5);
            2:       sigIn = ~sigIn;
            3:       sigIn = 1'b0;
            default: sigIn = (($urandom % 4) == 0);
        endcase
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, " relaxEnableA"}, relaxEnableA, 0);
        chk({tag, " busyA"}, busyA, 0);
        chk({tag, " resultValidA"}, resultValidA, 0);
        chk({tag, " overflowA"}, overflowA, 0);
        chk({tag, " relaxEnableB"}, relaxEnableB, 0);
        chk({tag, " busyB"}, busyB, 0);
        chk({tag, " resultValidB"}, resultValidB, 0);
        chk({tag, " overflowB"}, overflowB, 0);
    endtask

    // One full measurement: start, settle, gate, optional held DONE, handshake.
    task automatic runMeas(input string tag, input int settle, input int m, input int hold);
        int tStart;
        int n;
        int maxA;
        int maxB;
        int expA;
        int expB;
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " start relaxEnable"}, relaxEnableA, 1);
        chk({tag, " start busy"}, busyB, 1);
        repeat (settle) tick();
        chk({tag, " settle relaxEnable"}, relaxEnableA, 1);
        chk({tag, " settle valid"}, resultValidA, 0);
        relaxSignal = 1'b1;
        tStart = cyc;
        tick();
        relaxSignal = 1'($urandom % 2);
        repeat (G - 1) tick();
        chk({tag, " valid before close"}, resultValidA, 0);
        tick();
        n = 0;
        for (int e = tStart + 1; e <= tStart + G; e++) begin
            if (sHist[e - S] && !sHist[e - S - 1]) n++;
        end
        maxA = (1 << WA) - 1;
        maxB = (1 << WB) - 1;
        expA = (n > maxA) ? maxA : n;
        expB = (n > maxB) ? maxB : n;
        chk({tag, " validA"}, resultValidA, 1);
        chk({tag, " validB"}, resultValidB, 1);
        chk({tag, " resultA"}, resultA, expA);
        chk({tag, " resultB"}, resultB, expB);
        chk({tag, " overflowA"}, overflowA, (n > maxA) ? 1 : 0);
        chk({tag, " overflowB"}, overflowB, (n > maxB) ? 1 : 0);
        chk({tag, " done relaxEnable"}, relaxEnableA, 0);
        chk({tag, " done busy"}, busyA, 1);
        expResA = expA;
        expResB = expB;
        relaxSignal = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = 1'($urandom % 2);
            tick();
        end
        start = 1'b0;
        if (hold > 0) begin
            chk({tag, " held resultA"}, resultA, expA);
            chk({tag, " held validA"}, resultValidA, 1);
            chk({tag, " held busyB"}, busyB, 1);
        end
        resultReady = 1'b1;
        start = 1'b1;
        tick();
        resultReady = 1'b0;
        start = 1'b0;
        chk({tag, " ack validA"}, resultValidA, 0);
        chk({tag, " ack busyA"}, busyA, 0);
        chk({tag, " ack busyB"}, busyB, 0);
        tick();
        chk({tag, " idle after ack busy"}, busyA, 0);
        chk({tag, " idle after ack relaxEnable"}, relaxEnableA, 0);
    endtask

    initial begin
        mode = 3;
        repeat (3) tick();
        chkIdle("reset");
        chk("reset resultA", resultA, 0);
        chk("reset resultB", resultB, 0);
        sysRst = 1'b0;
        tick();
        chkIdle("post reset");

        // Period-10 input, settle 20 cycles: ten edges in the gate.
        runMeas("T1", 20, 1, 0);
        // Toggle every cycle: 50 edges saturate both widths.
        runMeas("T2", 5, 2, 0);
        // Held DONE while start is pulsed.
        runMeas("T3", 8, 1, 50);

        for (int k = 0; k < 6; k++) begin
            runMeas("RND", $urandom_range(3, 30), ($urandom % 2 == 0) ? 0 : 4, $urandom_range(0, 5));
        end

        // Abort while settling.
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chkIdle("abort settle");
        chk("abort settle result kept", resultA, expResA);
        repeat (10) tick();
        chk("abort settle no valid", resultValidA, 0);

        // Abort mid-gate after the 4-bit count has saturated.
        mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        relaxSignal = 1'b1;
        tick();
        relaxSignal = 1'b0;
        repeat (60) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chkIdle("abort gate");
        chk("abort gate resultB kept", resultB, expResB);
        repeat (G) tick();
        chk("abort gate no validA", resultValidA, 0);
        chk("abort gate no validB", resultValidB, 0);

        // Reset mid-gate, then a full measurement.
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        relaxSignal = 1'b1;
        tick();
        relaxSignal = 1'b0;
        repeat (40) tick();
        sysRst = 1'b1;
        tick();
        sysRst = 1'b0;
        chkIdle("mid reset");
        chk("mid reset resultA", resultA, 0);
        chk("mid reset resultB", resultB, 0);
        runMeas("T5", 5, 1, 0);

        // Long settle with no relaxSignal.
        runMeas("T6", 1000, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
